// File: rtl/soc_system_spi_slave_pkg.sv
// Shared constants and types for the SPI slave: register map, status/control bit
// positions, FSM states and the default frame width.
package soc_system_spi_slave_pkg;
  localparam int DATABITS_DEF = 16;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int ST_ROE  = 3;
  localparam int ST_TOE  = 4;
  localparam int ST_TMT  = 5;
  localparam int ST_TRDY = 6;
  localparam int ST_RRDY = 7;
  localparam int ST_E    = 8;
  localparam int ST_TUR  = 9;

  typedef enum logic [1:0] {IDLE, SHIFT, LAST} state_e;
endpackage

// File: rtl/soc_system_spi_slave_sync.sv
// N-stage input synchronizer with registered rise/fall pulses aligned to the level output.
module soc_system_spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              last_q, rise_q, fall_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {STAGES{RST_VAL}};
      last_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      last_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~last_q;
      fall_q <= ~sync_q[STAGES-1] & last_q;
    end
  end

  assign q_o    = last_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/soc_system_spi_slave.sv
// SPI slave (CPOL=1, CPHA=0) with a CPU register port; oversamples the SPI pins on clk.
// Define SOC_SYSTEM_SPI_SLAVE_LSBFIRST_EN to shift LSB first in both directions.
module soc_system_spi_slave
  import soc_system_spi_slave_pkg::*;
#(
  parameter int DATABITS    = DATABITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                SCLK,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic                MISO_oe,
  input  logic [2:0]          mem_addr,
  input  logic                spi_select,
  input  logic                read_n,
  input  logic                write_n,
  input  logic [DATABITS-1:0] data_from_cpu,
  output logic [DATABITS-1:0] data_to_cpu,
  output logic                irq,
  output logic                dataavailable,
  output logic                readyfordata
);
  localparam int CW = $clog2(DATABITS);

  logic sclk_lvl, sclk_rise, sclk_fall, ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall, unused_sync;

  soc_system_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
    .clk_i(clk), .reset_i(reset), .d_i(SCLK), .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  soc_system_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk_i(clk), .reset_i(reset), .d_i(SS_n), .q_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));
  soc_system_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk_i(clk), .reset_i(reset), .d_i(MOSI), .q_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign unused_sync = ^{sclk_lvl, ss_lvl, mosi_rise, mosi_fall};

  state_e              state_q, state_d;
  logic [DATABITS-1:0] tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d, rx_hold_q, rx_hold_d;
  logic [DATABITS-2:0] rx_shift_q, rx_shift_d;
  logic [DATABITS-1:0] ctrl_q, ctrl_d, wdata_q, rdata_q, status, rx_word, tx_next;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic                primed_q, primed_d, roe_q, roe_d, toe_q, toe_d, tur_q, tur_d, rrdy_q, rrdy_d;
  logic                rd_stb_q, wr_stb_q, rd_act_q, wr_act_q, irq_q, load, rd_clr;
  logic [2:0]          addr_q;

  wire rd_p1 = ~rd_stb_q & spi_select & ~read_n;
  wire wr_p1 = ~wr_stb_q & spi_select & ~write_n;

`ifdef SOC_SYSTEM_SPI_SLAVE_LSBFIRST_EN
  assign rx_word = {mosi_lvl, rx_shift_q};
  assign tx_next = {1'b0, tx_shift_q[DATABITS-1:1]};
  assign MISO    = tx_shift_q[0];
`else
  assign rx_word = {rx_shift_q, mosi_lvl};
  assign tx_next = {tx_shift_q[DATABITS-2:0], 1'b0};
  assign MISO    = tx_shift_q[DATABITS-1];
`endif

  always_comb begin
    status          = '0;
    status[ST_ROE]  = roe_q;
    status[ST_TOE]  = toe_q;
    status[ST_TMT]  = ~primed_q & (state_q == IDLE);
    status[ST_TRDY] = ~primed_q;
    status[ST_RRDY] = rrdy_q;
    status[ST_E]    = roe_q | toe_q | tur_q;
    status[ST_TUR]  = tur_q;
  end

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_hold_d  = tx_hold_q;
    rx_hold_d  = rx_hold_q;
    bitcnt_d   = bitcnt_q;
    primed_d   = primed_q;
    roe_d      = roe_q;
    toe_d      = toe_q;
    tur_d      = tur_q;
    rrdy_d     = rrdy_q;
    ctrl_d     = ctrl_q;
    load       = 1'b0;
    rd_clr     = rd_act_q && (addr_q == ADDR_RXDATA);
    // CPU side is applied first so that flag sets from the shifter win the same cycle.
    if (wr_act_q && addr_q == ADDR_STATUS) begin
      roe_d = 1'b0;
      toe_d = 1'b0;
      tur_d = 1'b0;
    end
    if (wr_act_q && addr_q == ADDR_CONTROL) ctrl_d = wdata_q;
    if (wr_act_q && addr_q == ADDR_TXDATA) begin
      if (primed_q) toe_d = 1'b1;
      else begin
        tx_hold_d = wdata_q;
        primed_d  = 1'b1;
      end
    end
    if (rd_clr) rrdy_d = 1'b0;

    if (ss_rise) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (ss_fall) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
        SHIFT: if (sclk_fall) begin
`ifdef SOC_SYSTEM_SPI_SLAVE_LSBFIRST_EN
          rx_shift_d = rx_word[DATABITS-1:1];
`else
          rx_shift_d = rx_word[DATABITS-2:0];
`endif
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == CW'(DATABITS - 1)) begin
            rx_hold_d = rx_word;
            rrdy_d    = 1'b1;
            if (rrdy_q && !rd_clr) roe_d = 1'b1;
            bitcnt_d  = '0;
            state_d   = LAST;
          end
        end else if (sclk_rise) tx_shift_d = tx_next;
        LAST: if (sclk_rise) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
        default: state_d = IDLE;
      endcase
    end

    // An unprimed load still primes from a same-cycle write: the write targets the next frame.
    if (load) begin
      bitcnt_d = '0;
      if (primed_q) begin
        tx_shift_d = tx_hold_q;
        primed_d   = 1'b0;
      end else begin
        tx_shift_d = '0;
        tur_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      tx_hold_q  <= '0;
      rx_hold_q  <= '0;
      bitcnt_q   <= '0;
      primed_q   <= 1'b0;
      roe_q      <= 1'b0;
      toe_q      <= 1'b0;
      tur_q      <= 1'b0;
      rrdy_q     <= 1'b0;
      ctrl_q     <= '0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      rd_act_q   <= 1'b0;
      wr_act_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      tx_hold_q  <= tx_hold_d;
      rx_hold_q  <= rx_hold_d;
      bitcnt_q   <= bitcnt_d;
      primed_q   <= primed_d;
      roe_q      <= roe_d;
      toe_q      <= toe_d;
      tur_q      <= tur_d;
      rrdy_q     <= rrdy_d;
      ctrl_q     <= ctrl_d;
      rd_stb_q   <= spi_select & ~read_n;
      wr_stb_q   <= spi_select & ~write_n;
      rd_act_q   <= rd_p1;
      wr_act_q   <= wr_p1;
      if (rd_p1 || wr_p1) begin
        addr_q  <= mem_addr;
        wdata_q <= data_from_cpu;
      end
      case (mem_addr)
        ADDR_RXDATA:  rdata_q <= rx_hold_q;
        ADDR_STATUS:  rdata_q <= status;
        ADDR_CONTROL: rdata_q <= ctrl_q;
        default:      rdata_q <= '0;
      endcase
      irq_q <= |(status & ctrl_q & ~(DATABITS'(1) << ST_TMT));
    end
  end

  assign MISO_oe       = (state_q != IDLE);
  assign data_to_cpu   = rdata_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = ~primed_q;
endmodule

// File: tb/tb_soc_system_spi_slave.sv
// Directed bench for soc_system_spi_slave: host frames and CPU accesses checked against a scoreboard.
module tb_soc_system_spi_slave;
  localparam int HALF  = 6;
  localparam int SETUP = 8;
  localparam logic [2:0] A_RX = 3'd0, A_TX = 3'd1, A_ST = 3'd2, A_CTL = 3'd3;

  logic        clk = 1'b0, reset = 1'b1, SCLK = 1'b1, SS_n = 1'b1, MOSI = 1'b0;
  logic        MISO, MISO_oe, irq, dataavailable, readyfordata;
  logic [2:0]  mem_addr = 3'd0;
  logic        spi_select = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [15:0] data_from_cpu = '0, data_to_cpu;

  int          checks = 0, errors = 0;
  logic [15:0] exp_miso_q[$], exp_rx_q[$];
  logic [15:0] host_tx, host_rx, st;

  soc_system_spi_slave dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .MISO_oe(MISO_oe), .mem_addr(mem_addr), .spi_select(spi_select), .read_n(read_n),
    .write_n(write_n), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .irq(irq), .dataavailable(dataavailable), .readyfordata(readyfordata));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    tick(2);
    spi_select = 1'b0; write_n = 1'b1; mem_addr = A_RX;
    tick(1);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] v);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    tick(1);
    v = data_to_cpu;
    tick(1);
    spi_select = 1'b0; read_n = 1'b1; mem_addr = A_RX;
    tick(1);
  endtask

  // The holding register keeps only the newest word, so older pending entries are dropped.
  task automatic read_rx();
    logic [15:0] v;
    cpu_read(A_RX, v);
    while (exp_rx_q.size() > 1) exp_rx_q.delete(0);
    if (exp_rx_q.size() == 0) check("rxdata_no_expect", v, ~v);
    else check("rxdata", v, exp_rx_q.pop_front());
  endtask

  task automatic host_bits(input int n);
    for (int i = 0; i < n; i++) begin
      MOSI = host_tx[15];
      tick(HALF);
      SCLK = 1'b0;
      host_rx = {host_rx[14:0], MISO};
      tick(HALF);
      SCLK = 1'b1;
      host_tx = host_tx << 1;
    end
  endtask

  task automatic host_frame(input logic [15:0] tx, input logic [15:0] exp_miso);
    exp_miso_q.push_back(exp_miso);
    exp_rx_q.push_back(tx);
    SS_n = 1'b0;
    tick(SETUP);
    host_tx = tx; host_rx = '0;
    host_bits(16);
    tick(HALF);
    SS_n = 1'b1;
    tick(8);
    check("miso_word", host_rx, exp_miso_q.pop_front());
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_miso", MISO, 1'b0);
    check("rst_miso_oe", MISO_oe, 1'b0);
    check("rst_data_to_cpu", data_to_cpu, 16'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_dataavailable", dataavailable, 1'b0);
    check("rst_readyfordata", readyfordata, 1'b1);
    cpu_read(A_ST, st);
    check("rst_status", st, 16'h0060);

    // Primed word goes out while the host word comes in
    cpu_write(A_TX, 16'hA5C3);
    check("primed_trdy", readyfordata, 1'b0);
    host_frame(16'h1234, 16'hA5C3);
    check("t1_dataavailable", dataavailable, 1'b1);
    cpu_read(A_ST, st);
    check("t1_rrdy", st[7], 1'b1);
    check("t1_tmt", st[5], 1'b1);
    read_rx();
    check("t1_rrdy_clr", dataavailable, 1'b0);
    cpu_write(A_ST, 16'h0);

    // Underrun with its interrupt enabled
    cpu_write(A_CTL, 16'h0200);
    host_frame(16'h0F0F, 16'h0000);
    cpu_read(A_ST, st);
    check("t2_status", st, 16'h03E0);
    check("t2_irq", irq, 1'b1);
    read_rx();
    cpu_write(A_ST, 16'hFFFF);
    tick(1);
    check("t2_irq_clr", irq, 1'b0);
    cpu_write(A_CTL, 16'h0000);

    // Overrun: two frames, no read in between
    host_frame(16'h1111, 16'h0000);
    host_frame(16'h2222, 16'h0000);
    cpu_read(A_ST, st);
    check("t3_roe", st[3], 1'b1);
    check("t3_e", st[8], 1'b1);
    read_rx();
    cpu_write(A_ST, 16'h0);
    cpu_read(A_ST, st);
    check("t3_roe_clr", st[3], 1'b0);

    // Transmit overrun keeps the first word
    cpu_write(A_TX, 16'hBEEF);
    cpu_write(A_TX, 16'hCAFE);
    cpu_read(A_ST, st);
    check("t4_status", st, 16'h0110);
    host_frame(16'h3333, 16'hBEEF);
    read_rx();
    cpu_write(A_ST, 16'h0);

    // Aborted frame leaves the received word and flags alone
    host_frame(16'h4444, 16'h0000);
    SS_n = 1'b0;
    tick(SETUP);
    host_tx = 16'h7777; host_rx = '0;
    host_bits(7);
    check("t5_oe_mid", MISO_oe, 1'b1);
    tick(HALF);
    SS_n = 1'b1;
    tick(8);
    check("t5_oe_idle", MISO_oe, 1'b0);
    check("t5_rrdy_kept", dataavailable, 1'b1);
    cpu_read(A_ST, st);
    check("t5_roe", st[3], 1'b0);
    read_rx();
    cpu_write(A_TX, 16'h9C3A);
    host_frame(16'h6D5E, 16'h9C3A);
    read_rx();
    cpu_write(A_ST, 16'h0);

    // Back-to-back words under one SS_n, re-primed mid-word
    cpu_write(A_TX, 16'h1357);
    exp_miso_q.push_back(16'h1357);
    exp_rx_q.push_back(16'hA1A1);
    SS_n = 1'b0;
    tick(SETUP);
    host_tx = 16'hA1A1; host_rx = '0;
    host_bits(8);
    cpu_write(A_TX, 16'h2468);
    host_bits(8);
    check("b2b_miso0", host_rx, exp_miso_q.pop_front());
    check("b2b_oe", MISO_oe, 1'b1);
    read_rx();
    exp_miso_q.push_back(16'h2468);
    exp_rx_q.push_back(16'hB2B2);
    host_tx = 16'hB2B2; host_rx = '0;
    host_bits(16);
    tick(HALF);
    SS_n = 1'b1;
    tick(8);
    check("b2b_miso1", host_rx, exp_miso_q.pop_front());
    read_rx();
    cpu_read(A_ST, st);
    check("b2b_roe", st[3], 1'b0);
    check("b2b_toe", st[4], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/soc_system_spi_slave.md
# soc_system_spi_slave

16-bit SPI slave with a memory-mapped CPU register port. It is the peer of the SoC's SPI master and lets the FPGA fabric act as the target of an external SPI host. The slave uses the same frame format as the master: CPOL=1, CPHA=0, MSB first, one slave select. It oversamples SCLK/SS_n/MOSI on the system clock, shifts a CPU-supplied word out on MISO and captures the incoming word into a receive holding register. It also provides the same status, control, IRQ and streaming ready flags as the master.

## Interface
- DATABITS, 16, frame width in bits.
- SYNC_STAGES, 2, synchronizer depth for SCLK, SS_n and MOSI (≥2).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock from the external host; idles high.
- SS_n  in  1  active-low slave select.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out.
- MISO_oe  out  1  MISO output enable; drives the pad tristate.
- mem_addr  in  3  register address: 0 rxdata (r), 1 txdata (w), 2 status (r/w), 3 control (r/w).
- spi_select, read_n, write_n  in  1 each  slave-port chipselect and active-low strobes.
- data_from_cpu  in  16  write data.
- data_to_cpu  out  16  registered read data.
- irq  out  1  registered interrupt.
- dataavailable  out  1  equals RRDY.
- readyfordata  out  1  equals TRDY.

## Operation
- Reads and writes are two-cycle events. p1 strobe = ~strobe_reg & spi_select & ~read_n (or ~write_n); the action fires in the registered cycle. data_to_cpu is updated every clk from the mem_addr mux.
- Status bits: [3] ROE, [4] TOE, [5] TMT, [6] TRDY, [7] RRDY, [8] E=ROE|TOE|TUR, [9] TUR (transmit underrun). All other bits read 0.
- Control register: the bit positions listed above are IRQ enables; TMT has no enable. irq_reg <= OR of (flag & enable).
- Writing status (any data) clears ROE, TOE and TUR.
- Transmit path:
  - txdata write when not primed: tx_holding <= data, primed <= 1.
  - txdata write when primed: the data is dropped and TOE <= 1.
  - TRDY = ~primed.
  - TMT = ~primed & (state==IDLE).
- FSM:
  - IDLE: MISO_oe=0. On a synchronized SS_n falling edge, load the shift register, set bitcnt=0, go to SHIFT.
  - Load rule: if primed, shift <= tx_holding and primed <= 0. Otherwise shift <= 0 and TUR <= 1.
  - SHIFT: on a synchronized SCLK falling edge, sample MOSI into rx_shift and increment bitcnt. At the 16th sample: rx_holding <= word, RRDY <= 1, ROE <= 1 if RRDY was already set; go to LAST. On SCLK rising edges, shift tx out.
  - LAST: on an SCLK rising edge, perform the load rule (back-to-back frame) and go to SHIFT.
  - Any state: a synchronized SS_n rising edge forces IDLE. A partial word is discarded: RRDY and rx_holding are unchanged and no flag is set.
- MISO = shift MSB, or LSB with the LSB-first option. MISO_oe = (state≠IDLE).
- Simultaneous events:
  - rxdata read-clear in the same cycle as frame completion: set wins, and ROE is not set.
  - CPU write in the same cycle as a load with primed=0: the load sends 0x0000 and sets TUR, and the write primes the holding register for the next frame.
  - Status write in the same cycle as a flag set: the set wins.

## Timing
- Reset values:
  - Outputs: MISO 0, MISO_oe 0, data_to_cpu 0, irq 0, dataavailable 0, readyfordata 1.
  - Internal state: IDLE, all flags 0, holding registers 0.
- Reset asserted mid-frame returns everything to reset values immediately. The host frame in progress is lost.
- Input latency: SYNC_STAGES + 1 clk from pin edge to edge detect.
- SS_n pin fall to valid first MISO bit: SYNC_STAGES + 2 clk.
- 16th SCLK pin fall to RRDY/dataavailable: SYNC_STAGES + 2 clk.
- irq follows its flag by 1 clk.
- Constraints on the host: SCLK high and low times ≥ SYNC_STAGES + 2 clk (max SCLK = clk/8 with defaults), and SS_n-fall to first SCLK edge ≥ SYNC_STAGES + 3 clk.

## Configuration
- SOC_SYSTEM_SPI_SLAVE_LSBFIRST_EN defined: transmit and receive LSB first; MISO = shift[0].
- Undefined: MSB first, matching the master.

## Structure
- Package soc_system_spi_slave_pkg holds:
  - register address constants;
  - status/control bit-position constants;
  - the FSM state enum (IDLE, SHIFT, LAST);
  - the DATABITS default.
- Sub-module soc_system_spi_slave_sync, instantiated three times (SCLK, SS_n, MOSI): an N-stage synchronizer plus registered rise/fall pulse outputs.

## Test plan
- txdata=0xA5C3, host sends 0x1234 in one frame → host receives 0xA5C3; rxdata=0x1234; RRDY=1, TMT=1.
- No txdata write, host frame → MISO shifts 0x0000, TUR=1, E=1; irq=1 with control bit9 set.
- Two frames without an rxdata read → ROE=1; rxdata holds the second word. Status write → ROE=0.
- txdata written twice before a frame → TOE=1; the first value is transmitted.
- SS_n raised after 7 bits → IDLE, RRDY unchanged, MISO_oe=0. The next full frame is received correctly.
- SS_n held low for 32 SCLKs with txdata re-primed between words → two words are transferred each way, back to back.
